acct_query_arbiter: RTL

- Shares the account RAM read port (72-bit entries: id[47:0] in bits 71:24, balance[23:0] in bits 23:0) between the transaction validator and a host balance-query engine.
- The validator always has priority on the read port.
- The query engine scans entries 0..count_i-1 for a requested 48-bit id in free read slots and returns found flag, balance and index.
- It snoops RAM writes so results never go stale.

---
 rtl/acct_pkg.sv | 31 +++
 rtl/acct_query_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/acct_pkg.sv
// Shared widths, entry layout and query FSM encoding for the account-RAM
// balance-query arbiter.
package acct_pkg;

    localparam int ID_W   = 48;
    localparam int BAL_W  = 24;
    localparam int ADDR_W = 14;
    localparam int MEM_W  = ID_W + BAL_W;

    localparam logic [ADDR_W-1:0] UNDEFINED_PTR = {ADDR_W{1'b1}};

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [BAL_W-1:0] balance;
    } acct_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } query_state_e;

    function automatic logic [MEM_W-1:0] pack_entry(input logic [ID_W-1:0] id,
                                                    input logic [BAL_W-1:0] balance);
        acct_entry_t e;
        e.id      = id;
        e.balance = balance;
        return e;
    endfunction

endpackage

// File: rtl/acct_query_arbiter.sv
// Shares the account RAM read port between the validator (always wins) and a
// host balance-query engine that scans free read slots and snoops writes.
module acct_query_arbiter
    import acct_pkg::*;
#(
    parameter int ID_W   = acct_pkg::ID_W,
    parameter int BAL_W  = acct_pkg::BAL_W,
    parameter int ADDR_W = acct_pkg::ADDR_W,
    localparam int MEM_W = ID_W + BAL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              val_rd_req_i,
    input  logic [ADDR_W-1:0] val_rd_addr_i,
    output logic [MEM_W-1:0]  val_rd_data_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [MEM_W-1:0]  mem_rd_data_i,
    input  logic              mem_wr_en_i,
    input  logic [ADDR_W-1:0] mem_wr_addr_i,
    input  logic [MEM_W-1:0]  mem_wr_data_i,
    input  logic [ADDR_W-1:0] count_i,
    input  logic              q_valid_i,
    output logic              q_ready_o,
    input  logic [ID_W-1:0]   q_id_i,
    output logic              r_valid_o,
    input  logic              r_ready_i,
    output logic              r_found_o,
    output logic [BAL_W-1:0]  r_balance_o,
    output logic [ADDR_W-1:0] r_index_o
);

    query_state_e      r_state;
    logic [ID_W-1:0]   r_qid;
    logic [ADDR_W:0]   r_scan_addr;
    logic              r_tag_v;
    logic [ADDR_W-1:0] r_tag_addr;

    logic              w_scan_room;
    logic              w_issue;
    logic              w_rd_match;
    logic              w_wr_match;

    // Extra MSB on the scan pointer lets a full-depth count terminate cleanly.
    assign w_scan_room   = r_scan_addr < {1'b0, count_i};
    assign w_issue       = (r_state == ST_SCAN) && !val_rd_req_i && w_scan_room;
    assign w_rd_match    = r_tag_v && (mem_rd_data_i[MEM_W-1:BAL_W] == r_qid);
    assign w_wr_match    = mem_wr_en_i && (mem_wr_data_i[MEM_W-1:BAL_W] == r_qid);

    assign val_rd_data_o = mem_rd_data_i;
    assign q_ready_o     = (r_state == ST_IDLE);
    assign r_valid_o     = (r_state == ST_DONE);

    // Read-port mux: validator owns the port whenever it asks.
    always_comb begin
        if (val_rd_req_i) begin
            mem_rd_addr_o = val_rd_addr_i;
        end else begin
            mem_rd_addr_o = r_scan_addr[ADDR_W-1:0];
        end
    end

    // Query FSM: accept, scan free slots, snoop writes, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_qid       <= {ID_W{1'b0}};
            r_scan_addr <= {(ADDR_W+1){1'b0}};
            r_tag_v     <= 1'b0;
            r_tag_addr  <= {ADDR_W{1'b0}};
            r_found_o   <= 1'b0;
            r_balance_o <= {BAL_W{1'b0}};
            r_index_o   <= {ADDR_W{1'b1}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tag_v <= 1'b0;
                    if (q_valid_i) begin
                        r_qid       <= q_id_i;
                        r_scan_addr <= {(ADDR_W+1){1'b0}};
                        r_found_o   <= 1'b0;
                        r_balance_o <= {BAL_W{1'b0}};
                        r_index_o   <= {ADDR_W{1'b1}};
                        r_state     <= (count_i == {ADDR_W{1'b0}}) ? ST_DONE : ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    r_tag_v    <= w_issue;
                    r_tag_addr <= r_scan_addr[ADDR_W-1:0];
                    if (w_issue) begin
                        r_scan_addr <= r_scan_addr + {{ADDR_W{1'b0}}, 1'b1};
                    end
                    // A write carrying the id is newer than any read in flight.
                    if (w_wr_match) begin
                        r_found_o   <= 1'b1;
                        r_balance_o <= mem_wr_data_i[BAL_W-1:0];
                        r_index_o   <= mem_wr_addr_i;
                        r_tag_v     <= 1'b0;
                        r_state     <= ST_DONE;
                    end else if (w_rd_match) begin
                        r_found_o   <= 1'b1;
                        r_balance_o <= mem_rd_data_i[BAL_W-1:0];
                        r_index_o   <= r_tag_addr;
                        r_tag_v     <= 1'b0;
                        r_state     <= ST_DONE;
                    end else if (!r_tag_v && !w_scan_room) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_tag_v <= 1'b0;
                    if (r_ready_i) begin
                        r_state <= ST_IDLE;
                    end else if (mem_wr_en_i) begin
                        if (r_found_o && (mem_wr_addr_i == r_index_o)) begin
                            r_balance_o <= mem_wr_data_i[BAL_W-1:0];
                        end else if (!r_found_o && w_wr_match) begin
                            r_found_o   <= 1'b1;
                            r_balance_o <= mem_wr_data_i[BAL_W-1:0];
                            r_index_o   <= mem_wr_addr_i;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tag_v <= 1'b0;
                end
            endcase
        end
    end

endmodule
